load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: four-state data-memory access FSM with byte/half/word alignment,
// lane replication for stores and sign/zero extension for loads.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [3:0]        i_d_size,
  input  logic              i_d_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [3:0]        o_dmem_be,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [31:0]       i_dmem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, size_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [1:0]        off_q;
  logic              uns_q, we_q, err_q;
  logic              legal, mis, valid, bad;
  logic [3:0]        be_w;
  logic [31:0]       wdata_w, shifted, ext;
  assign legal   = i_d_size == 4'b0001 || i_d_size == 4'b0011 || i_d_size == 4'b1111;
  assign mis     = (i_d_size == 4'b0011 && i_addr[0]) || (i_d_size == 4'b1111 && i_addr[1:0] != 2'b00);
  assign valid   = (i_mem_read ^ i_mem_write) && legal && !mis;
  assign bad     = (i_mem_read || i_mem_write) && !valid;
  assign be_w    = i_d_size << i_addr[1:0];
  assign wdata_w = i_d_size == 4'b0001 ? {4{i_wdata[7:0]}} :
                   i_d_size == 4'b0011 ? {2{i_wdata[15:0]}} : i_wdata;
  assign shifted = i_dmem_rdata >> {off_q, 3'b000};
  assign ext     = size_q == 4'b0001 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                   size_q == 4'b0011 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
  // Reset gates the combinational stall so nothing leaks out while rst_n is low
  assign o_stall      = i_rst_n && ((state_q == IDLE && valid) || state_q == REQ || state_q == WAIT);
  assign o_dmem_req   = state_q == REQ;
  assign o_dmem_we    = we_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_rdata      = rdata_q;
  assign o_err        = err_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid) begin
            addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
            off_q   <= i_addr[1:0];
            be_q    <= be_w;
            wdata_q <= wdata_w;
            size_q  <= i_d_size;
            uns_q   <= i_d_unsigned;
            we_q    <= i_mem_write;
            state_q <= REQ;
          end else if (bad) begin
            err_q <= 1'b1;
          end
        end
        REQ: begin
          cnt_q <= '0;
          if (i_dmem_gnt) state_q <= we_q ? DONE : WAIT;
        end
        WAIT: begin
          if (i_dmem_rvalid) begin
            rdata_q <= ext;
            state_q <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
